// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: opcode/func constants, select encodings, state and class types for the multicycle controller
package mc_ctrl_pkg;

    localparam logic [5:0] OP_R_FORM = 6'h00;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [1:0] PCSEL_PC4 = 2'd0;
    localparam logic [1:0] PCSEL_BR  = 2'd1;
    localparam logic [1:0] PCSEL_JMP = 2'd2;
    localparam logic [1:0] PCSEL_RS  = 2'd3;

    localparam logic [1:0] WSEL_RT  = 2'd0;
    localparam logic [1:0] WSEL_RD  = 2'd1;
    localparam logic [1:0] WSEL_R31 = 2'd2;

    localparam logic [1:0] WBSEL_ALU = 2'd0;
    localparam logic [1:0] WBSEL_MEM = 2'd1;
    localparam logic [1:0] WBSEL_PC4 = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5
    } state_t;

    typedef struct packed {
        logic ralu;
        logic ialu;
        logic lw;
        logic sw;
        logic br;
        logic bne;
        logic j;
        logic jal;
        logic jr;
        logic jalr;
        logic ill;
    } cls_t;

    function automatic logic is_alu_func(input logic [5:0] f);
        return f inside {FN_SLL, FN_SRL, FN_SRA, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                         FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU};
    endfunction

    function automatic logic is_ialu_op(input logic [5:0] o);
        return o inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI};
    endfunction

endpackage

// File: rtl/mc_ctrl_dec.sv
// mc_ctrl_dec: maps op/func to a one-hot instruction class
module mc_ctrl_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] func_i,
    output cls_t       cls_o
);

    logic r_form;

    assign r_form = (op_i == OP_R_FORM);

    // Class decode; anything not recognised falls through to illegal
    always_comb begin
        cls_o      = '0;
        cls_o.jr   = r_form && (func_i == FN_JR);
        cls_o.jalr = r_form && (func_i == FN_JALR);
        cls_o.ralu = r_form && is_alu_func(func_i);
        cls_o.ialu = is_ialu_op(op_i);
        cls_o.lw   = (op_i == OP_LW);
        cls_o.sw   = (op_i == OP_SW);
        cls_o.br   = (op_i == OP_BEQ);
        cls_o.bne  = (op_i == OP_BNE);
        cls_o.j    = (op_i == OP_J);
        cls_o.jal  = (op_i == OP_JAL);
        cls_o.ill  = ~|{cls_o.jr, cls_o.jalr, cls_o.ralu, cls_o.ialu, cls_o.lw, cls_o.sw,
                        cls_o.br, cls_o.bne, cls_o.j, cls_o.jal};
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS control sequencer (IF/ID/EX/MEM/WB) with memory handshakes and ack timeout
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TMO_CYC = 255
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             run_i,
    input  logic [5:0]       op_i,
    input  logic [5:0]       func_i,
    input  logic             alu_zero_i,
    input  logic             imem_ack_i,
    input  logic             dmem_ack_i,
    output logic             imem_req_o,
    output logic             dmem_req_o,
    output logic             dmem_we_o,
    output logic             ir_we_o,
    output logic             pc_we_o,
    output logic [1:0]       pc_sel_o,
    output logic             rf_re_o,
    output logic             rf_we_o,
    output logic [1:0]       rf_wsel_o,
    output logic [1:0]       wb_sel_o,
    output logic             alu_src_o,
    output logic             retire_o,
    output logic             exc_ill_o,
    output logic             bus_err_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    localparam int TMO_W = $clog2(TMO_CYC + 2);

    state_t             state_q, state_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    cls_t               cls;
    logic               tmo_hit;
    state_t             end_st;

    mc_ctrl_dec u_dec (
        .op_i   (op_i),
        .func_i (func_i),
        .cls_o  (cls)
    );

    assign tmo_hit     = (TMO_CYC != 0) && (tmo_q == TMO_W'(TMO_CYC));
    assign end_st      = run_i ? S_IF : S_IDLE;
    assign instr_cnt_o = cnt_q;

    // Next state and all control outputs, decoded from state, class, acks and alu_zero
    always_comb begin
        state_d    = state_q;
        imem_req_o = 1'b0;
        dmem_req_o = 1'b0;
        dmem_we_o  = 1'b0;
        ir_we_o    = 1'b0;
        pc_we_o    = 1'b0;
        pc_sel_o   = PCSEL_PC4;
        rf_re_o    = 1'b0;
        rf_we_o    = 1'b0;
        rf_wsel_o  = WSEL_RT;
        wb_sel_o   = WBSEL_ALU;
        alu_src_o  = 1'b0;
        retire_o   = 1'b0;
        exc_ill_o  = 1'b0;
        bus_err_o  = 1'b0;
        case (state_q)
            S_IDLE: state_d = run_i ? S_IF : S_IDLE;
            S_IF: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) begin
                    ir_we_o = 1'b1;
                    pc_we_o = 1'b1;
                    state_d = S_ID;
                end else if (tmo_hit) begin
                    bus_err_o = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_ID: begin
                rf_re_o   = 1'b1;
                pc_we_o   = cls.j | cls.jal;
                pc_sel_o  = (cls.j | cls.jal) ? PCSEL_JMP : PCSEL_PC4;
                retire_o  = cls.j | cls.jal;
                rf_we_o   = cls.jal;
                rf_wsel_o = cls.jal ? WSEL_R31 : WSEL_RT;
                wb_sel_o  = cls.jal ? WBSEL_PC4 : WBSEL_ALU;
                exc_ill_o = cls.ill;
                state_d   = (cls.j | cls.jal | cls.ill) ? end_st : S_EX;
            end
            S_EX: begin
                alu_src_o = cls.ialu | cls.lw | cls.sw;
                pc_we_o   = (cls.br & alu_zero_i) | (cls.bne & ~alu_zero_i) | cls.jr | cls.jalr;
                pc_sel_o  = (cls.jr | cls.jalr) ? PCSEL_RS : (cls.br | cls.bne) ? PCSEL_BR : PCSEL_PC4;
                rf_we_o   = cls.jalr;
                rf_wsel_o = cls.jalr ? WSEL_RD : WSEL_RT;
                wb_sel_o  = cls.jalr ? WBSEL_PC4 : WBSEL_ALU;
                retire_o  = cls.br | cls.bne | cls.jr | cls.jalr;
                state_d   = retire_o ? end_st : (cls.lw | cls.sw) ? S_MEM : S_WB;
            end
            S_MEM: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = cls.sw;
                if (dmem_ack_i) begin
                    retire_o = cls.sw;
                    state_d  = cls.sw ? end_st : S_WB;
                end else if (tmo_hit) begin
                    bus_err_o = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_WB: begin
                rf_we_o   = 1'b1;
                rf_wsel_o = cls.ralu ? WSEL_RD : WSEL_RT;
                wb_sel_o  = cls.lw ? WBSEL_MEM : WBSEL_ALU;
                retire_o  = 1'b1;
                state_d   = end_st;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Timeout counter restarts when a request phase is entered; retire counter wraps naturally
    always_comb begin
        tmo_d = ((state_d != state_q) && (state_d == S_IF || state_d == S_MEM)) ? '0 :
                ((imem_req_o & ~imem_ack_i) | (dmem_req_o & ~dmem_ack_i)) ? tmo_q + TMO_W'(1) : tmo_q;
        cnt_d = cnt_q + CNT_W'(retire_o);
    end

    // State and counter registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed and randomized instruction streams checked against a per-class behaviour model
module tb_mc_ctrl;

    localparam int K_RALU = 0, K_IALU = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5;
    localparam int K_J = 6, K_JAL = 7, K_JR = 8, K_JALR = 9, K_ILL = 10;

    logic clk = 1'b0;
    logic rst_n, run, alu_zero;
    logic [5:0] op, fn;
    logic a_iack, a_dack, b_iack, b_dack;

    logic a_imem_req, a_dmem_req, a_dmem_we, a_ir_we, a_pc_we, a_rf_re, a_rf_we, a_alu_src;
    logic a_retire, a_exc_ill, a_bus_err;
    logic [1:0] a_pc_sel, a_rf_wsel, a_wb_sel;
    logic [3:0] a_instr_cnt;
    logic b_imem_req, b_dmem_req, b_dmem_we, b_ir_we, b_pc_we, b_rf_re, b_rf_we, b_alu_src;
    logic b_retire, b_exc_ill, b_bus_err;
    logic [1:0] b_pc_sel, b_rf_wsel, b_wb_sel;
    logic [3:0] b_instr_cnt;

    int total = 0;
    int bad = 0;
    int exp_cnt = 0;
    bit idle_exp = 1'b1;
    logic [5:0] ops [18] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                             6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h0B, 6'h3F};

    always #5 clk = ~clk;

    mc_ctrl #(.CNT_W(4), .TMO_CYC(8)) u_a (
        .clk_i(clk), .rst_n_i(rst_n), .run_i(run), .op_i(op), .func_i(fn), .alu_zero_i(alu_zero),
        .imem_ack_i(a_iack), .dmem_ack_i(a_dack), .imem_req_o(a_imem_req), .dmem_req_o(a_dmem_req),
        .dmem_we_o(a_dmem_we), .ir_we_o(a_ir_we), .pc_we_o(a_pc_we), .pc_sel_o(a_pc_sel),
        .rf_re_o(a_rf_re), .rf_we_o(a_rf_we), .rf_wsel_o(a_rf_wsel), .wb_sel_o(a_wb_sel),
        .alu_src_o(a_alu_src), .retire_o(a_retire), .exc_ill_o(a_exc_ill), .bus_err_o(a_bus_err),
        .instr_cnt_o(a_instr_cnt)
    );

    mc_ctrl #(.CNT_W(4), .TMO_CYC(4)) u_b (
        .clk_i(clk), .rst_n_i(rst_n), .run_i(run), .op_i(op), .func_i(fn), .alu_zero_i(alu_zero),
        .imem_ack_i(b_iack), .dmem_ack_i(b_dack), .imem_req_o(b_imem_req), .dmem_req_o(b_dmem_req),
        .dmem_we_o(b_dmem_we), .ir_we_o(b_ir_we), .pc_we_o(b_pc_we), .pc_sel_o(b_pc_sel),
        .rf_re_o(b_rf_re), .rf_we_o(b_rf_we), .rf_wsel_o(b_rf_wsel), .wb_sel_o(b_wb_sel),
        .alu_src_o(b_alu_src), .retire_o(b_retire), .exc_ill_o(b_exc_ill), .bus_err_o(b_bus_err),
        .instr_cnt_o(b_instr_cnt)
    );

    function automatic int kind_of(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'h00: return (f == 6'h08) ? K_JR : (f == 6'h09) ? K_JALR :
                          (f inside {6'h00, 6'h02, 6'h03, [6'h20:6'h27], 6'h2A, 6'h2B}) ? K_RALU : K_ILL;
            6'h02: return K_J;
            6'h03: return K_JAL;
            6'h04: return K_BEQ;
            6'h05: return K_BNE;
            6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E: return K_IALU;
            6'h23: return K_LW;
            6'h2B: return K_SW;
            default: return K_ILL;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one instruction through u_a and check every phase against the class rules
    task automatic do_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                            input int id, input int dd, input logic run_end);
        int k;
        bit done;
        k = kind_of(o, f);
        if (idle_exp) begin
            @(negedge clk); run = 1'b1; a_iack = 1'b1; #1;
            chk("idle_req", a_imem_req, 0);
            chk("idle_ack_ignored", a_ir_we, 0);
        end
        for (int c = 0; c < id; c++) begin
            @(negedge clk); a_iack = 1'b0; #1;
            chk("if_wait_req", a_imem_req, 1);
            chk("if_wait_irwe", a_ir_we, 0);
        end
        @(negedge clk); a_iack = 1'b1; op = o; fn = f; #1;
        chk("if_req", a_imem_req, 1);
        chk("if_irwe", a_ir_we, 1);
        chk("if_pcwe", a_pc_we, 1);
        chk("if_pcsel", a_pc_sel, 0);
        chk("if_retire", a_retire, 0);
        @(negedge clk); a_iack = 1'b0; a_dack = 1'b1; run = run_end; #1;
        chk("id_rfre", a_rf_re, 1);
        chk("id_ireq_low", a_imem_req, 0);
        chk("id_dreq", a_dmem_req, 0);
        if (k == K_J || k == K_JAL) begin
            chk("id_pcwe", a_pc_we, 1);
            chk("id_pcsel", a_pc_sel, 2);
            chk("id_retire", a_retire, 1);
            chk("id_rfwe", a_rf_we, k == K_JAL);
            if (k == K_JAL) begin
                chk("id_wsel", a_rf_wsel, 2);
                chk("id_wbsel", a_wb_sel, 2);
            end
        end else begin
            chk("id_exc", a_exc_ill, k == K_ILL);
            chk("id_retire", a_retire, 0);
            chk("id_pcwe", a_pc_we, 0);
            chk("id_rfwe", a_rf_we, 0);
        end
        done = (k == K_J || k == K_JAL || k == K_ILL);
        if (!done) begin
            @(negedge clk); a_dack = 1'b0; alu_zero = z; #1;
            chk("ex_rfre", a_rf_re, 0);
            chk("ex_alusrc", a_alu_src, k == K_IALU || k == K_LW || k == K_SW);
            done = (k == K_BEQ || k == K_BNE || k == K_JR || k == K_JALR);
            chk("ex_retire", a_retire, done);
            chk("ex_pcwe", a_pc_we, (k == K_BEQ && z) || (k == K_BNE && !z) || k == K_JR || k == K_JALR);
            if (k == K_BEQ || k == K_BNE) chk("ex_pcsel", a_pc_sel, 1);
            if (k == K_JR || k == K_JALR) chk("ex_pcsel", a_pc_sel, 3);
            chk("ex_rfwe", a_rf_we, k == K_JALR);
            if (k == K_JALR) begin
                chk("ex_wsel", a_rf_wsel, 1);
                chk("ex_wbsel", a_wb_sel, 2);
            end
        end
        if (k == K_LW || k == K_SW) begin
            for (int c = 0; c < dd; c++) begin
                @(negedge clk); a_dack = 1'b0; #1;
                chk("mem_wait_req", a_dmem_req, 1);
                chk("mem_wait_we", a_dmem_we, k == K_SW);
                chk("mem_wait_retire", a_retire, 0);
            end
            @(negedge clk); a_dack = 1'b1; #1;
            chk("mem_req", a_dmem_req, 1);
            chk("mem_we", a_dmem_we, k == K_SW);
            chk("mem_retire", a_retire, k == K_SW);
            chk("mem_rfwe", a_rf_we, 0);
            done = (k == K_SW);
        end
        if (!done) begin
            @(negedge clk); a_dack = 1'b0; #1;
            chk("wb_dreq", a_dmem_req, 0);
            chk("wb_rfwe", a_rf_we, 1);
            chk("wb_wsel", a_rf_wsel, k == K_RALU);
            chk("wb_wbsel", a_wb_sel, k == K_LW);
            chk("wb_retire", a_retire, 1);
        end
        if (k != K_ILL) exp_cnt = (exp_cnt + 1) % 16;
        @(negedge clk); a_dack = 1'b0; #1;
        chk("end_cnt", a_instr_cnt, exp_cnt);
        chk("end_ireq", a_imem_req, run_end);
        chk("end_dreq", a_dmem_req, 0);
        chk("end_retire", a_retire, 0);
        idle_exp = !run_end;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; run = 1'b0; alu_zero = 1'b0; op = '0; fn = '0;
        a_iack = 1'b0; a_dack = 1'b0; b_iack = 1'b0; b_dack = 1'b0;
        #12;
        chk("rst_ireq", a_imem_req, 0);
        chk("rst_cnt", a_instr_cnt, 0);
        chk("rst_rfwe", a_rf_we, 0);
        chk("rst_b_ireq", b_imem_req, 0);
        @(negedge clk); rst_n = 1'b1;

        do_instr(6'h00, 6'h20, 1'b0, 2, 0, 1'b1);
        do_instr(6'h23, 6'h00, 1'b0, 0, 5, 1'b1);
        do_instr(6'h2B, 6'h00, 1'b0, 1, 2, 1'b1);
        do_instr(6'h04, 6'h00, 1'b1, 0, 0, 1'b1);
        do_instr(6'h04, 6'h00, 1'b0, 0, 0, 1'b1);
        do_instr(6'h05, 6'h00, 1'b1, 0, 0, 1'b1);
        do_instr(6'h05, 6'h00, 1'b0, 0, 0, 1'b1);
        do_instr(6'h03, 6'h00, 1'b0, 0, 0, 1'b1);
        do_instr(6'h02, 6'h00, 1'b0, 1, 0, 1'b1);
        do_instr(6'h00, 6'h08, 1'b0, 0, 0, 1'b1);
        do_instr(6'h00, 6'h09, 1'b0, 0, 0, 1'b1);
        do_instr(6'h08, 6'h00, 1'b0, 0, 0, 1'b1);
        do_instr(6'h3F, 6'h00, 1'b0, 0, 0, 1'b1);
        do_instr(6'h00, 6'h3F, 1'b0, 0, 0, 1'b1);
        do_instr(6'h23, 6'h00, 1'b0, 0, 3, 1'b0);
        do_instr(6'h00, 6'h25, 1'b0, 1, 0, 1'b1);

        @(negedge clk); #1;
        chk("pre_rst_ireq", a_imem_req, 1);
        #2; rst_n = 1'b0; #1;
        chk("async_rst_ireq", a_imem_req, 0);
        chk("async_rst_cnt", a_instr_cnt, 0);
        chk("async_rst_irwe", a_ir_we, 0);
        chk("async_rst_pcwe", a_pc_we, 0);
        @(negedge clk); run = 1'b0; rst_n = 1'b1;
        exp_cnt = 0; idle_exp = 1'b1;

        while (exp_cnt != 15) do_instr(6'h00, 6'h21, 1'b0, 0, 0, 1'b1);
        do_instr(6'h0D, 6'h00, 1'b0, 0, 0, 1'b1);
        chk("cnt_wrap", a_instr_cnt, 0);

        for (int i = 0; i < 40; i++) begin
            logic [5:0] o, f;
            o = ops[$urandom_range(0, 17)];
            f = 6'($urandom_range(0, 63));
            do_instr(o, f, 1'($urandom_range(0, 1)), $urandom_range(0, 5), $urandom_range(0, 5),
                     $urandom_range(0, 3) != 0);
        end

        @(negedge clk); rst_n = 1'b0; run = 1'b0; b_iack = 1'b0;
        @(negedge clk); rst_n = 1'b1; run = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk); #1;
            chk("tmo_req", b_imem_req, 1);
            chk("tmo_buserr", b_bus_err, c == 5);
            chk("tmo_irwe", b_ir_we, 0);
        end
        @(negedge clk); #1;
        chk("tmo_idle_req", b_imem_req, 0);
        chk("tmo_buserr_gone", b_bus_err, 0);
        chk("tmo_cnt", b_instr_cnt, 0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk); b_iack = (c == 5); #1;
            chk("late_ack_req", b_imem_req, 1);
            chk("late_ack_buserr", b_bus_err, 0);
            chk("late_ack_irwe", b_ir_we, c == 5);
        end
        @(negedge clk); b_iack = 1'b0; #1;
        chk("late_ack_id", b_rf_re, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
